apb_slave_mux: RTL and testbench

Parametrised APB decoder and response multiplexer between the AHB-to-APB bridge master side and up to 16 APB peripherals. It decodes a configurable address field into a one-hot slave select and holds that select for the whole transfer. It multiplexes PRDATA, PREADY and PSLVERR back to the bridge. Unmapped addresses get a default error response, and stalled slaves are aborted by a wait-state timeout. Error statistics are kept for debug.

---
 rtl/apb_slave_mux.sv | 179 +++++++++++++++++
 tb/tb_apb_slave_mux.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mux.sv
// apb_slave_mux: APB address decoder and response multiplexer for up to 16
// peripherals. The slave index sits in a configurable PADDR field and is held
// for the whole transfer. Unmapped indices get an immediate error response,
// and a stalled slave is aborted after TIMEOUT_CYCLES wait states (0 disables
// the timeout). Erroring completions are counted and their address is kept.
// Legal parameter space: 1 <= NUM_SLAVES <= 16, 2**SEL_BITS >= NUM_SLAVES.
`timescale 1ns/1ps

module apb_slave_mux #(
   parameter int NUM_SLAVES     = 8,
   parameter int SEL_LSB        = 12,
   parameter int SEL_BITS       = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                 PCLK,
   input  logic                                 PRESETn,
   input  logic [31:0]                          PADDR,
   input  logic                                 PSEL,
   input  logic                                 PENABLE,
   input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] PRData_in,
   input  logic [NUM_SLAVES-1:0]                PREADY_in,
   input  logic [NUM_SLAVES-1:0]                PSLVERR_in,
   output logic [NUM_SLAVES-1:0]                PSEL_slave,
   output logic [DATA_WIDTH-1:0]                PRDATA,
   output logic                                 PREADY,
   output logic                                 PSLVERR,
   output logic                                 timeout_pulse,
   output logic [7:0]                           err_count,
   output logic [31:0]                          last_err_addr
);

   // A zero timeout still gets a 1-bit counter so no signal collapses to width 0.
   localparam int                   CNT_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]     CNT_MAX      = CNT_W'(TIMEOUT_CYCLES);
   localparam bit                   TO_EN        = (TIMEOUT_CYCLES > 0);
   // One extra bit so NUM_SLAVES == 2**SEL_BITS is still representable.
   localparam logic [SEL_BITS:0]    NUM_SLAVES_W = (SEL_BITS + 1)'(NUM_SLAVES);

   typedef enum logic {
      ST_IDLE,
      ST_ACCESS
   } state_e;

   state_e                state_q, state_d;
   logic [SEL_BITS-1:0]   idx_q, idx_d;
   logic                  unmap_q, unmap_d;
   logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic [7:0]            err_count_q, err_count_d;
   logic [31:0]           last_err_addr_q, last_err_addr_d;
   logic                  timeout_pulse_q, timeout_pulse_d;

   logic [SEL_BITS-1:0]   live_idx;
   logic                  live_unmap;
   logic                  sel_ready;
   logic                  sel_err;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  abort;
   logic [NUM_SLAVES-1:0] resp_sel;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  resp_ready;
   logic                  resp_err;

   assign live_idx   = PADDR[SEL_LSB +: SEL_BITS];
   assign live_unmap = ({1'b0, live_idx} >= NUM_SLAVES_W);

   // Pick the held slave's ready/error/data; an unmapped index matches nothing.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_data  = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (idx_q == SEL_BITS'(s)) begin
            sel_ready = PREADY_in[s];
            sel_err   = PSLVERR_in[s];
            sel_data  = PRData_in[s];
         end
      end
   end

   // A live slave response in the boundary cycle wins over the abort.
   assign abort = TO_EN && (state_q == ST_ACCESS) && PSEL && !unmap_q &&
                  !sel_ready && (wait_cnt_q == CNT_MAX);

   // Select and response towards the bridge, before the reset gate.
   always_comb begin
      resp_sel   = '0;
      resp_data  = '0;
      resp_ready = 1'b0;
      resp_err   = 1'b0;
      if (state_q == ST_IDLE) begin
         // Live decode so the setup phase reaches the peripheral this cycle.
         for (int s = 0; s < NUM_SLAVES; s++) begin
            if (live_idx == SEL_BITS'(s)) resp_sel[s] = PSEL;
         end
      end else if (PSEL) begin
         if (unmap_q || abort) begin
            resp_ready = 1'b1;
            resp_err   = 1'b1;
         end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
               if (idx_q == SEL_BITS'(s)) resp_sel[s] = 1'b1;
            end
            resp_data  = sel_data;
            resp_ready = sel_ready;
            resp_err   = sel_ready & sel_err;
         end
      end
   end

   // NOTE: the combinational outputs are forced low by PRESETn directly, so they are quiet the instant reset asserts; only the outputs see this gate, never a flop's D input.
   assign PSEL_slave    = PRESETn ? resp_sel   : '0;
   assign PRDATA        = PRESETn ? resp_data  : '0;
   assign PREADY        = PRESETn & resp_ready;
   assign PSLVERR       = PRESETn & resp_err;
   assign timeout_pulse = timeout_pulse_q;
   assign err_count     = err_count_q;
   assign last_err_addr = last_err_addr_q;

   // Next state: transfer tracking, wait-state counting and error bookkeeping.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      unmap_d         = unmap_q;
      wait_cnt_d      = wait_cnt_q;
      err_count_d     = err_count_q;
      last_err_addr_d = last_err_addr_q;
      timeout_pulse_d = abort;
      case (state_q)
         ST_IDLE: begin
            if (PSEL && !PENABLE) begin
               idx_d      = live_idx;
               unmap_d    = live_unmap;
               wait_cnt_d = '0;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               // Bridge dropped the transfer: leave silently, no bookkeeping.
               state_d = ST_IDLE;
            end else if (resp_ready) begin
               state_d = ST_IDLE;
               if (resp_err) begin
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                  last_err_addr_d = PADDR;
               end
            end else if (TO_EN && (wait_cnt_q != CNT_MAX)) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q         <= ST_IDLE;
         idx_q           <= '0;
         unmap_q         <= 1'b0;
         wait_cnt_q      <= '0;
         err_count_q     <= '0;
         last_err_addr_q <= '0;
         timeout_pulse_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the values from before this edge, independent of statement order.
         state_q         <= state_d;
         idx_q           <= idx_d;
         unmap_q         <= unmap_d;
         wait_cnt_q      <= wait_cnt_d;
         err_count_q     <= err_count_d;
         last_err_addr_q <= last_err_addr_d;
         timeout_pulse_q <= timeout_pulse_d;
      end
   end

endmodule

// File: tb/tb_apb_slave_mux.sv
// Self-checking bench for apb_slave_mux. A transaction-level model predicts,
// per transfer, the cycle on which the slave, the unmapped default or the
// timeout answers, plus the error counter, captured address and pulse.
`timescale 1ns/1ps

module tb_apb_slave_mux;

   localparam int NS = 6;
   localparam int SL = 12;
   localparam int SB = 4;
   localparam int DW = 32;
   localparam int TO = 4;

   logic                  PCLK = 1'b0;
   logic                  PRESETn;
   logic [31:0]           PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic [NS-1:0][DW-1:0] PRData_in;
   logic [NS-1:0]         PREADY_in;
   logic [NS-1:0]         PSLVERR_in;
   logic [NS-1:0]         PSEL_slave;
   logic [DW-1:0]         PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   logic                  timeout_pulse;
   logic [7:0]            err_count;
   logic [31:0]           last_err_addr;

   int checks = 0;
   int errors = 0;

   // Reference state: what the registered outputs must show next cycle.
   int          m_err_cnt;
   logic [31:0] m_last_addr;
   bit          m_pulse;

   apb_slave_mux #(
      .NUM_SLAVES    (NS),
      .SEL_LSB       (SL),
      .SEL_BITS      (SB),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .PADDR        (PADDR),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PRData_in    (PRData_in),
      .PREADY_in    (PREADY_in),
      .PSLVERR_in   (PSLVERR_in),
      .PSEL_slave   (PSEL_slave),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .PSLVERR      (PSLVERR),
      .timeout_pulse(timeout_pulse),
      .err_count    (err_count),
      .last_err_addr(last_err_addr)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_err_cnt   = 0;
      m_last_addr = '0;
      m_pulse     = 1'b0;
   endtask

   // Random traffic from every peripheral; the target is overridden afterwards.
   task automatic noise();
      for (int s = 0; s < NS; s++) begin
         PRData_in[s]  = $urandom;
         PREADY_in[s]  = 1'($urandom_range(0, 1));
         PSLVERR_in[s] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".sel"},   PSEL_slave,    '0);
      check({tag, ".data"},  PRDATA,        '0);
      check({tag, ".rdy"},   PREADY,        '0);
      check({tag, ".err"},   PSLVERR,       '0);
      check({tag, ".pulse"}, timeout_pulse, '0);
      check({tag, ".cnt"},   err_count,     '0);
      check({tag, ".addr"},  last_err_addr, '0);
   endtask

   // One clock cycle: inputs are already driven; check at the falling edge,
   // then advance the model across the rising edge that ends the cycle.
   task automatic step(input logic [NS-1:0] e_sel, input bit e_rdy, input bit e_err,
                       input logic [31:0] e_data, input bit e_abort, input string tag);
      @(negedge PCLK);
      check({tag, ".sel"},   PSEL_slave,    e_sel);
      check({tag, ".rdy"},   PREADY,        e_rdy);
      check({tag, ".err"},   PSLVERR,       e_err);
      check({tag, ".data"},  PRDATA,        e_data);
      check({tag, ".pulse"}, timeout_pulse, m_pulse);
      check({tag, ".cnt"},   err_count,     m_err_cnt);
      check({tag, ".addr"},  last_err_addr, m_last_addr);
      m_pulse = e_abort;
      if (e_rdy && e_err) begin
         if (m_err_cnt < 255) m_err_cnt++;
         m_last_addr = PADDR;
      end
      @(posedge PCLK);
      #1;
   endtask

   task automatic idle_cycle();
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PADDR   = $urandom;
      noise();
      step('0, 1'b0, 1'b0, '0, 1'b0, "idle");
   endtask

   // Full transfer: the target slave raises PREADY_in after w wait states.
   // tog scrambles PADDR on every access cycle.
   task automatic xfer(input logic [31:0] addr, input int w, input logic [31:0] data,
                       input bit err, input bit tog);
      int            idx;
      bit            mapped;
      logic [NS-1:0] oh;
      idx    = int'(addr[SL +: SB]);
      mapped = (idx < NS);
      oh     = '0;
      if (mapped) oh[idx] = 1'b1;

      PADDR   = addr;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      noise();
      step(oh, 1'b0, 1'b0, '0, 1'b0, "setup");

      PENABLE = 1'b1;
      for (int k = 1; k <= TO + 1; k++) begin
         noise();
         if (tog) PADDR = $urandom;
         if (!mapped) begin
            step('0, 1'b1, 1'b1, '0, 1'b0, "unmap");
            break;
         end
         PREADY_in[idx] = (k > w);
         if (k > w) begin
            PSLVERR_in[idx] = err;
            PRData_in[idx]  = data;
            step(oh, 1'b1, err, data, 1'b0, "done");
            break;
         end else if (k == TO + 1) begin
            step('0, 1'b1, 1'b1, '0, 1'b1, "abort");
            break;
         end else begin
            step(oh, 1'b0, 1'b0, PRData_in[idx], 1'b0, "wait");
         end
      end
   endtask

   initial begin
      logic [31:0] a;
      PRESETn = 1'b0;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PADDR   = 32'h0000_3004;
      noise();
      model_reset();
      #3;
      check_all_zero("reset");

      @(posedge PCLK);
      #1;
      PRESETn = 1'b1;
      idle_cycle();

      // Mapped read, zero waits.
      xfer(32'h0000_3004, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      idle_cycle();

      // Unmapped index 7 with six slaves.
      xfer(32'h0000_7000, 0, '0, 1'b0, 1'b0);
      idle_cycle();
      check("unmap.cnt_is_1", err_count, 8'd1);
      check("unmap.addr", last_err_addr, 32'h0000_7000);

      // Slave 1 stalls forever: abort, then exactly one pulse cycle.
      xfer(32'h0000_1000, 99, '0, 1'b0, 1'b0);
      idle_cycle();
      idle_cycle();

      // Slave 2 answers in the very cycle the timeout would fire.
      xfer(32'h0000_2000, TO, 32'h1234_5678, 1'b0, 1'b0);
      idle_cycle();

      // Back-to-back with PADDR scrambled during the slave-0 access.
      xfer(32'h0000_0010, 2, 32'hA5A5_0001, 1'b0, 1'b1);
      xfer(32'h0000_5000, 0, 32'h5A5A_0005, 1'b1, 1'b0);
      idle_cycle();

      // Asynchronous reset in the middle of an access.
      PADDR   = 32'h0000_2000;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      noise();
      step(6'h04, 1'b0, 1'b0, '0, 1'b0, "rst_setup");
      PENABLE = 1'b1;
      noise();
      PREADY_in[2] = 1'b0;
      step(6'h04, 1'b0, 1'b0, PRData_in[2], 1'b0, "rst_wait");
      PREADY_in[2] = 1'b0;
      #1;
      PRESETn = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(posedge PCLK);
      #1;
      PRESETn = 1'b1;
      idle_cycle();
      xfer(32'h0000_4008, 1, 32'hCAFE_F00D, 1'b0, 1'b0);

      // Randomized traffic: mapped/unmapped, waits past the timeout, gaps.
      for (int n = 0; n < 150; n++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[SL +: SB] = 4'($urandom_range(0, NS - 1));
         else                           a[SL +: SB] = 4'($urandom_range(0, 15));
         xfer(a, int'($urandom_range(0, TO + 2)), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle();
      end
      idle_cycle();

      // Saturation: many more error completions than the counter can hold.
      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         a[SL +: SB] = 4'($urandom_range(NS, 15));
         xfer(a, 0, '0, 1'b0, 1'b0);
      end
      idle_cycle();
      check("sat.cnt", err_count, 8'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
